// File: rtl/serial_add_ctrl_if.sv
// Requester-side bundle for the bit-serial adder controller.
// The requester drives operands and start, and observes busy/done and the result.
interface serial_add_ctrl_if #(
   parameter int WIDTH = 8
) ();

   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;

   // Requester: issues operations and consumes results.
   modport master (
      output start, a, b, cin,
      input  busy, done, sum, cout
   );

   // Adder controller: accepts operations and returns results.
   modport slave (
      input  start, a, b, cin,
      output busy, done, sum, cout
   );

endinterface : serial_add_ctrl_if

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller.
// A single 1-bit full-adder cell is reused across WIDTH clocks, LSB first,
// with the carry held in a flop between bits. The requester sees a
// start/busy/done handshake; sum and cout are registered and held from the
// done pulse until the next operation starts shifting.
module serial_add_ctrl #(
   parameter int WIDTH = 8   // legal range 1..32
) (
   input  logic               clk,
   input  logic               rst,
   serial_add_ctrl_if.slave   bus
);

   // Counter wide enough to hold 0..WIDTH.
   localparam int            CNT_W    = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nxt;

   // Operand shift registers, consumed from bit 0.
   logic [WIDTH-1:0]  a_sr;
   logic [WIDTH-1:0]  b_sr;

   // Carry between bit slices, result shift register and registered carry-out.
   logic              carry;
   logic [WIDTH-1:0]  sum_sr;
   logic              cout_q;
   logic [CNT_W-1:0]  cnt;

   // Shared full-adder cell and handshake decodes.
   logic              fa_s;
   logic              fa_co;
   logic              accept;
   logic              running;
   logic              last_bit;
   logic [WIDTH:0]    sum_shift;

   logic              busy_o;
   logic              done_o;

   // The single full-adder cell time-multiplexed over all bit positions.
   assign fa_s  = a_sr[0] ^ b_sr[0] ^ carry;
   assign fa_co = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);

   assign accept   = (state == IDLE) && bus.start;
   assign running  = (state == RUN);
   assign last_bit = running && (cnt == LAST_BIT);

   // New sum bit enters at the MSB; the concatenation form also covers WIDTH=1.
   assign sum_shift = {fa_s, sum_sr};

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge value of every other flop, regardless of block order.
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic: accept in IDLE, count bits in RUN, one-cycle DONE.
   always_comb begin
      // NOTE: the default assignment up front keeps every path covered so no
      // latch is inferred for state_nxt.
      state_nxt = state;
      unique case (state)
         IDLE:    if (bus.start) state_nxt = RUN;
         RUN:     if (last_bit)  state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Handshake outputs decoded from the registered state.
   always_comb begin
      busy_o = 1'b0;
      done_o = 1'b0;
      unique case (state)
         IDLE:    ;
         RUN:     busy_o = 1'b1;
         DONE:    done_o = 1'b1;
         default: ;
      endcase
   end

   // Operand capture on accept and right shift while running.
   always_ff @(posedge clk) begin
      // NOTE: the operand shift registers carry no reset: they are always
      // loaded on accept before the adder reads them, so a reset adds nothing.
      if (accept) begin
         a_sr <= bus.a;
         b_sr <= bus.b;
      end else if (running) begin
         a_sr <= a_sr >> 1;
         b_sr <= b_sr >> 1;
      end
   end

   // Carry flop and bit counter: loaded on accept, advanced once per RUN bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         carry <= 1'b0;
         cnt   <= '0;
      end else if (accept) begin
         carry <= bus.cin;
         cnt   <= '0;
      end else if (running) begin
         carry <= fa_co;
         cnt   <= cnt + CNT_W'(1);
      end
   end

   // Result registers: only RUN edges and reset touch them, so the previous
   // result survives the accepting edge and stays visible until shifting starts.
   always_ff @(posedge clk) begin
      if (rst) begin
         sum_sr <= '0;
         cout_q <= 1'b0;
      end else if (running) begin
         sum_sr <= sum_shift[WIDTH:1];
         cout_q <= fa_co;
      end
   end

   assign bus.busy = busy_o;
   assign bus.done = done_o;
   assign bus.sum  = sum_sr;
   assign bus.cout = cout_q;

endmodule : serial_add_ctrl
